// File: rtl/linalg_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : linalg_pkg
//  Description : Shared types and width helpers for the fixed-point linear
//                algebra blocks (matvec_seq and its conversion sub-module).
//                  mv_state_t     - IDLE / BUSY / DONE controller states
//                  mv_prod_w      - exact signed product width for two operands
//                  mv_acc_w       - accumulator width that cannot overflow
//                  sfx_max/min    - signed range limits for a total bit width
//  Revision    : 1.0 - initial release
// ============================================================================
package linalg_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mv_state_t;

  // Exact product of two signed wi-bit operands.
  function automatic int mv_prod_w(input int wi);
    return 2 * wi;
  endfunction

  // Sum of n exact products; log2(n) guard bits keep it from overflowing.
  function automatic int mv_acc_w(input int wi, input int n);
    return 2 * wi + $clog2(n);
  endfunction

  // Largest signed value representable in w bits.
  function automatic longint sfx_max(input int w);
    return (longint'(1) <<< (w - 1)) - longint'(1);
  endfunction

  // Most negative signed value representable in w bits.
  function automatic longint sfx_min(input int w);
    return -(longint'(1) <<< (w - 1));
  endfunction

endpackage : linalg_pkg
`default_nettype wire

// File: rtl/fxp_shift_sat.sv
`default_nettype none
// ============================================================================
//  Module      : fxp_shift_sat
//  Description : Combinational fixed-point narrowing. Arithmetic right shift
//                (floor, no rounding), range check against the signed OUT_W
//                range, then either clamp or wrap the result.
//  Build macro : MATVEC_SAT_EN - defined: clamp to the signed limits
//                                undefined: keep the low OUT_W bits (wrap)
//                The overflow output is identical in both builds.
//  Ports       : din_i  [IN_W]  signed wide input
//                dout_o [OUT_W] narrowed result
//                ovf_o          shifted value does not fit in OUT_W bits
//  Revision    : 1.0 - initial release
// ============================================================================
module fxp_shift_sat
  import linalg_pkg::*;
#(
  parameter int IN_W  = 52,
  parameter int OUT_W = 25,
  parameter int SHIFT = 16
) (
  input  logic signed [IN_W-1:0]  din_i,
  output logic        [OUT_W-1:0] dout_o,
  output logic                    ovf_o
);

  localparam logic signed [IN_W-1:0] c_MAX = IN_W'(sfx_max(OUT_W));
  localparam logic signed [IN_W-1:0] c_MIN = IN_W'(sfx_min(OUT_W));

  logic signed [IN_W-1:0] w_shifted;

  // >>> on a signed operand rounds toward minus infinity.
  assign w_shifted = din_i >>> SHIFT;
  assign ovf_o     = (w_shifted > c_MAX) || (w_shifted < c_MIN);

`ifdef MATVEC_SAT_EN
  always_comb begin
    dout_o = w_shifted[OUT_W-1:0];
    if (ovf_o) begin
      dout_o = w_shifted[IN_W-1] ? c_MIN[OUT_W-1:0] : c_MAX[OUT_W-1:0];
    end
  end
`else
  assign dout_o = w_shifted[OUT_W-1:0];
`endif

endmodule : fxp_shift_sat
`default_nettype wire

// File: rtl/matvec_seq.sv
`default_nettype none
// ============================================================================
//  Module      : matvec_seq
//  Description : Sequential fixed-point N x N matrix by N-vector multiplier,
//                Pp[j] = sum_i H[i][j] * p[i], using a single time-shared MAC.
//                One MAC per BUSY cycle; result after N*N cycles.
//  Build macro : MATVEC_SAT_EN - clamp out-of-range results (else wrap)
//  Ports       : clk, reset_n        clock, async active-low reset
//                in_valid/in_ready   input handshake (H, p)
//                H [N][N][WII+WIF]   signed matrix, H[i][j] scales p[i] into Pp[j]
//                p [N][WII+WIF]      signed vector
//                out_valid/out_ready output handshake (Pp, overflow)
//                Pp [N][WOI+WOF]     signed result
//                overflow            some Pp element out of range this result
//  Revision    : 1.0 - initial release
// ============================================================================
module matvec_seq
  import linalg_pkg::*;
#(
  parameter int N   = 4,
  parameter int WII = 9,
  parameter int WIF = 16,
  parameter int WOI = 9,
  parameter int WOF = 16
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [N-1:0][N-1:0][WII+WIF-1:0]  H,
  input  logic [N-1:0][WII+WIF-1:0]         p,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [N-1:0][WOI+WOF-1:0]         Pp,
  output logic                              overflow
);

  localparam int IN_W   = WII + WIF;
  localparam int OUT_W  = WOI + WOF;
  localparam int PROD_W = mv_prod_w(IN_W);
  localparam int ACC_W  = mv_acc_w(IN_W, N);
  localparam int CW     = $clog2(N);
  localparam int SHIFT  = 2 * WIF - WOF;

  mv_state_t                        state_q, state_d;
  logic [CW-1:0]                    i_q, i_d, j_q, j_d;
  logic signed [ACC_W-1:0]          acc_q, acc_d;
  logic [N-1:0][N-1:0][IN_W-1:0]    h_q, h_d;
  logic [N-1:0][IN_W-1:0]           p_q, p_d;
  logic [N-1:0][OUT_W-1:0]          pp_q, pp_d;
  logic                             ovf_q, ovf_d;

  logic signed [IN_W-1:0]           w_h_sel, w_p_sel;
  logic signed [PROD_W-1:0]         w_prod;
  logic signed [ACC_W-1:0]          w_acc_sum;
  logic [OUT_W-1:0]                 w_conv;
  logic                             w_conv_ovf;
  logic                             w_accept, w_last_i, w_last_j;

  // MAC datapath: current term of row j is H[i][j] * p[i].
  assign w_h_sel   = h_q[i_q][j_q];
  assign w_p_sel   = p_q[i_q];
  assign w_prod    = w_h_sel * w_p_sel;
  assign w_acc_sum = acc_q + ACC_W'(w_prod);

  fxp_shift_sat #(
    .IN_W  (ACC_W),
    .OUT_W (OUT_W),
    .SHIFT (SHIFT)
  ) u_conv (
    .din_i  (w_acc_sum),
    .dout_o (w_conv),
    .ovf_o  (w_conv_ovf)
  );

  assign w_last_i  = (i_q == CW'(N - 1));
  assign w_last_j  = (j_q == CW'(N - 1));

  // in_ready depends only on state and out_ready, never on in_valid.
  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign w_accept  = in_valid && in_ready;

  assign out_valid = (state_q == DONE);
  assign Pp        = pp_q;
  assign overflow  = ovf_q;

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    acc_d   = acc_q;
    h_d     = h_q;
    p_d     = p_q;
    pp_d    = pp_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE: ;
      BUSY: begin
        if (w_last_i) begin
          // Row complete: the final term goes straight into the converter.
          pp_d[j_q] = w_conv;
          ovf_d     = ovf_q | w_conv_ovf;
          acc_d     = '0;
          i_d       = '0;
          if (w_last_j) begin
            j_d     = '0;
            state_d = DONE;
          end else begin
            j_d     = j_q + 1'b1;
          end
        end else begin
          acc_d = w_acc_sum;
          i_d   = i_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Acceptance (from IDLE, or from DONE on the same edge as the transfer).
    if (w_accept) begin
      h_d     = H;
      p_d     = p;
      i_d     = '0;
      j_d     = '0;
      acc_d   = '0;
      ovf_d   = 1'b0;
      state_d = BUSY;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
      acc_q   <= '0;
      h_q     <= '0;
      p_q     <= '0;
      pp_q    <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      acc_q   <= acc_d;
      h_q     <= h_d;
      p_q     <= p_d;
      pp_q    <= pp_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule : matvec_seq
`default_nettype wire

// File: tb/tb_matvec_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_matvec_seq
//  Description : Scoreboard bench for matvec_seq (N=4, Q9.16 in and out).
//                Stimulus pushes the hand-computed result; a negedge monitor
//                pops and compares on every output transfer and checks the
//                acceptance-to-out_valid latency.
//  Build macro : MATVEC_SAT_EN selects the clamped overflow expectation.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_matvec_seq;

  localparam int N = 4;
  localparam int W = 25;

  localparam logic [W-1:0] ONE   = 25'h0010000;  //  1.0
  localparam logic [W-1:0] HALF  = 25'h0008000;  //  0.5
  localparam logic [W-1:0] P1_5  = 25'h0018000;  //  1.5
  localparam logic [W-1:0] P2_0  = 25'h0020000;  //  2.0
  localparam logic [W-1:0] M2_0  = 25'h1FE0000;  // -2.0
  localparam logic [W-1:0] P3_25 = 25'h0034000;  //  3.25
  localparam logic [W-1:0] P4_0  = 25'h0040000;  //  4.0
  localparam logic [W-1:0] P200  = 25'h0C80000;  //  200.0
  localparam logic [W-1:0] M_LSB = 25'h1FFFFFF;  // -2^-16
`ifdef MATVEC_SAT_EN
  localparam logic [W-1:0] OVF_VAL = 25'h0FFFFFF;  // clamped positive
`else
  localparam logic [W-1:0] OVF_VAL = 25'h1000000;  // 160000*2^16 mod 2^25
`endif

  logic                       clk = 1'b0;
  logic                       reset_n;
  logic                       in_valid;
  logic                       in_ready;
  logic [N-1:0][N-1:0][W-1:0] H;
  logic [N-1:0][W-1:0]        p;
  logic                       out_valid;
  logic                       out_ready;
  logic [N-1:0][W-1:0]        Pp;
  logic                       overflow;

  matvec_seq #(.N(4), .WII(9), .WIF(16), .WOI(9), .WOF(16)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .H         (H),
    .p         (p),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Pp        (Pp),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0][W-1:0] pp;
    logic                ovf;
    string               nm;
  } exp_t;

  exp_t sb[$];
  int   accq[$];
  int   cyc     = 0;
  int   n_pass  = 0;
  int   n_total = 0;
  logic prev_v  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, required %h", nm, act, req);
  endtask

  // Monitor: acceptance edges, latency and output transfers.
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_v <= 1'b0;
    end else begin
      if (out_valid && !prev_v) begin
        if (accq.size() == 0) begin
          n_total++;
          $display("FAIL latency: out_valid with no acceptance recorded");
        end else begin
          chk("latency", 128'(cyc - accq.pop_front()), 128'(16));
        end
      end
      if (in_valid && in_ready) accq.push_back(cyc + 1);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_output: Pp=%h with empty scoreboard", Pp);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk({e.nm, "_Pp"}, 128'(Pp), 128'(e.pp));
          chk({e.nm, "_ovf"}, 128'(overflow), 128'(e.ovf));
        end
      end
      prev_v <= out_valid;
    end
  end

  task automatic send(input logic [N-1:0][N-1:0][W-1:0] h, input logic [N-1:0][W-1:0] v,
                      input logic [N-1:0][W-1:0] e_pp, input logic e_ovf, input string nm);
    sb.push_back('{pp: e_pp, ovf: e_ovf, nm: nm});
    H = h;
    p = v;
    in_valid = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
    end
    n_total++;
    $display("FAIL %s_accept_timeout: in_ready never 1, required 1", nm);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input string nm);
    for (int k = 0; k < 300; k++) begin
      @(posedge clk);
      #1;
      if (sb.size() == 0) return;
    end
    n_total++;
    $display("FAIL %s_timeout: scoreboard holds %0d entries, required 0", nm, sb.size());
    sb.delete();
  endtask

  logic [N-1:0][N-1:0][W-1:0] id_h, col_h, all_h, tr_h;
  logic [N-1:0][W-1:0]        id_p, col_p, all_p, tr_p, col_e, all_e, tr_e;
  bit                         seen;

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    H = '0;
    p = '0;

    id_h = '0;  col_h = '0;  tr_h = '0;
    for (int i = 0; i < N; i++) begin
      id_h[i][i] = ONE;
      for (int j = 0; j < N; j++) all_h[i][j] = P200;
      all_p[i] = P200;
      all_e[i] = OVF_VAL;
    end
    id_p[0] = P1_5;  id_p[1] = M2_0;  id_p[2] = P3_25;  id_p[3] = ONE;
    col_h[1][0] = HALF;
    col_h[3][2] = M2_0;
    col_p[0] = '0;   col_p[1] = P4_0; col_p[2] = '0;    col_p[3] = ONE;
    col_e[0] = P2_0; col_e[1] = '0;   col_e[2] = M2_0;  col_e[3] = '0;
    tr_h[0][0] = M_LSB;
    tr_p = '0;  tr_p[0] = HALF;
    tr_e = '0;  tr_e[0] = M_LSB;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", 128'(out_valid), 128'(1'b0));
    chk("reset_in_ready",  128'(in_ready),  128'(1'b1));
    chk("reset_Pp",        128'(Pp),        128'(0));
    chk("reset_ovf",       128'(overflow),  128'(1'b0));
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    send(id_h, id_p, id_p, 1'b0, "identity");
    wait_out("identity");
    send(col_h, col_p, col_e, 1'b0, "column");
    wait_out("column");
    send(all_h, all_p, all_e, 1'b1, "overflow");
    wait_out("overflow");
    send(id_h, id_p, id_p, 1'b0, "clean_after_ovf");
    wait_out("clean_after_ovf");

    // Back-pressure: out_ready low; next input presented but must be ignored.
    out_ready = 1'b0;
    send(col_h, col_p, col_e, 1'b0, "bp_column");
    sb.push_back('{pp: tr_e, ovf: 1'b0, nm: "truncation"});
    H = tr_h;
    p = tr_p;
    in_valid = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      n_total++;
      $display("FAIL bp_valid_timeout: out_valid never 1, required 1");
    end
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      chk("bp_out_valid", 128'(out_valid), 128'(1'b1));
      chk("bp_in_ready",  128'(in_ready),  128'(1'b0));
      chk("bp_Pp",        128'(Pp),        128'(col_e));
      chk("bp_ovf",       128'(overflow),  128'(1'b0));
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_in_ready", 128'(in_ready), 128'(1'b1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_out("truncation");

    // Reset in the middle of BUSY.
    send(id_h, id_p, id_p, 1'b0, "aborted");
    repeat (6) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    chk("midreset_out_valid", 128'(out_valid), 128'(1'b0));
    chk("midreset_in_ready",  128'(in_ready),  128'(1'b1));
    chk("midreset_Pp",        128'(Pp),        128'(0));
    chk("midreset_ovf",       128'(overflow),  128'(1'b0));
    sb.delete();
    accq.delete();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    send(id_h, id_p, id_p, 1'b0, "post_reset_identity");
    wait_out("post_reset_identity");

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_matvec_seq
`default_nettype wire
